// File: rtl/dist_ram_sync_fifo.sv
// Single-clock FIFO on distributed RAM with level-derived flags, standard or FWFT read.
// Optional sticky overflow/underflow flags are enabled by defining DIST_FIFO_ERR_FLAG_EN.
module dist_ram_sync_fifo #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  wr_acc, rd_acc;

  // Flags come straight from the registered level so they move on the same edge.
  always_comb begin
    full         = (level_q == DEPTH_L);
    empty        = (level_q == '0);
    almost_full  = (level_q >= AF_L);
    almost_empty = (level_q <= AE_L);
    level        = level_q;
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; a cleared level makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) rd_data_d = mem[rd_ptr_q];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

`ifdef DIST_FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  // A new error in the clear cycle keeps the flag set.
  always_comb begin
    overflow_d  = (wr_en && full)  || (overflow_q  && !err_clr);
    underflow_d = (rd_en && empty) || (underflow_q && !err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif
endmodule

// File: tb/tb_dist_ram_sync_fifo.sv
// Randomized + directed bench: standard and FWFT instances share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_dist_ram_sync_fifo;
  localparam int AW = 4, DW = 16, DEPTH = 16, AFN = 14, AEN = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [DW-1:0] s_rd_data, f_rd_data;
  logic [AW:0]   s_level, f_level;

  dist_ram_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(s_full),
    .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd_data), .empty(s_empty),
    .almost_empty(s_ae), .level(s_level), .overflow(s_ovf), .underflow(s_udf),
    .err_clr(err_clr));

  dist_ram_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(f_full),
    .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd_data), .empty(f_empty),
    .almost_empty(f_ae), .level(f_level), .overflow(f_ovf), .underflow(f_udf),
    .err_clr(err_clr));

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_std = '0;
  bit m_ovf = 0, m_udf = 0;
  int checks = 0, errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference update for one clock edge, using the inputs held across that edge.
  task automatic step();
    bit fl, em;
    fl = (q.size() == DEPTH);
    em = (q.size() == 0);
`ifdef DIST_FIFO_ERR_FLAG_EN
    m_ovf = (wr_en && fl) || (m_ovf && !err_clr);
    m_udf = (rd_en && em) || (m_udf && !err_clr);
`endif
    if (rd_en && !em) m_std = q.pop_front();
    if (wr_en && !fl) q.push_back(wr_data);
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_level", 32'(s_level), n);          chk("f_level", 32'(f_level), n);
    chk("s_full", 32'(s_full), 32'(n == DEPTH));  chk("f_full", 32'(f_full), 32'(n == DEPTH));
    chk("s_empty", 32'(s_empty), 32'(n == 0));    chk("f_empty", 32'(f_empty), 32'(n == 0));
    chk("s_af", 32'(s_af), 32'(n >= AFN));        chk("f_af", 32'(f_af), 32'(n >= AFN));
    chk("s_ae", 32'(s_ae), 32'(n <= AEN));        chk("f_ae", 32'(f_ae), 32'(n <= AEN));
    chk("s_rd_data", 32'(s_rd_data), 32'(m_std));
    if (n > 0) chk("f_rd_data", 32'(f_rd_data), 32'(q[0]));
    chk("s_ovf", 32'(s_ovf), 32'(m_ovf));         chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("s_udf", 32'(s_udf), 32'(m_udf));         chk("f_udf", 32'(f_udf), 32'(m_udf));
  endtask

  task automatic cyc(bit we, logic [DW-1:0] wd, bit re, bit ec);
    wr_en = we; wr_data = wd; rd_en = re; err_clr = ec;
    @(posedge clk);
    step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_level", 32'(s_level), 0);  chk("rst_empty", 32'(s_empty), 1);
    chk("rst_ae", 32'(s_ae), 1);        chk("rst_full", 32'(s_full), 0);
    chk("rst_af", 32'(s_af), 0);        chk("rst_rd_data", 32'(s_rd_data), 0);
    chk("rst_ovf", 32'(s_ovf), 0);      chk("rst_udf", 32'(s_udf), 0);
    rst_n = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, DW'(i + 1), 0, 0);
      if (i == 12) chk("t1_af_at13", 32'(s_af), 0);
      if (i == 13) chk("t1_af_at14", 32'(s_af), 1);
    end
    chk("t1_level16", 32'(s_level), 16);
    chk("t1_full", 32'(s_full), 1);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, '0, 1, 0);
      chk("t1_rd", 32'(s_rd_data), i + 1);
    end
    chk("t1_empty", 32'(s_empty), 1);

    // Write+read while full: write dropped.
    for (int i = 0; i < DEPTH; i++) cyc(1, DW'($urandom), 0, 0);
    cyc(1, 16'hDEAD, 1, 0);
    chk("t2_level15", 32'(s_level), 15);
`ifdef DIST_FIFO_ERR_FLAG_EN
    chk("t2_ovf_set", 32'(s_ovf), 1);
    cyc(0, '0, 0, 1);
    chk("t2_ovf_clr", 32'(s_ovf), 0);
`endif
    while (q.size() > 0) cyc(0, '0, 1, 0);

    // Read+write while empty: read dropped.
    cyc(1, 16'hABCD, 1, 0);
    chk("t3_level1", 32'(s_level), 1);
    chk("t3_not_empty", 32'(s_empty), 0);
    chk("t3_fwft_data", 32'(f_rd_data), 32'h ABCD);
`ifdef DIST_FIFO_ERR_FLAG_EN
    chk("t3_udf_set", 32'(s_udf), 1);
    cyc(0, '0, 0, 1);
`endif
    cyc(0, '0, 1, 0);
    chk("t3_rd", 32'(s_rd_data), 32'h ABCD);

    // FWFT: data visible one cycle after write into empty.
    cyc(1, 16'h0055, 0, 0);
    chk("t5_f_empty0", 32'(f_empty), 0);
    chk("t5_f_data", 32'(f_rd_data), 32'h55);
    cyc(0, '0, 1, 0);
    chk("t5_f_empty1", 32'(f_empty), 1);

    // Streaming at level 5 across pointer wrap.
    for (int i = 0; i < 5; i++) cyc(1, DW'(95 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, DW'(100 + i), 1, 0);
      chk("t4_level5", 32'(s_level), 5);
      chk("t4_rd", 32'(s_rd_data), 95 + i);
    end
    while (q.size() > 0) cyc(0, '0, 1, 0);

    // Randomized phases biased toward filling or draining.
    for (int ph = 0; ph < 8; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 80 : 25;
      rp = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 250; i++)
        cyc($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp,
            $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-stream at level 9.
    while (q.size() > 0) cyc(0, '0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(1, DW'(16'h0200 + i), 0, 0);
    chk("t6_level9", 32'(s_level), 9);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete(); m_std = '0; m_ovf = 0; m_udf = 0;
    chk("t6_level0", 32'(s_level), 0);
    chk("t6_empty", 32'(s_empty), 1);
    chk("t6_full", 32'(s_full), 0);
    chk("t6_rd_data0", 32'(s_rd_data), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 16'h0077, 0, 0);
    cyc(1, 16'h0078, 0, 0);
    cyc(0, '0, 1, 0);
    chk("t6_rd77", 32'(s_rd_data), 32'h77);
    cyc(0, '0, 1, 0);
    chk("t6_rd78", 32'(s_rd_data), 32'h78);
    chk("t6_empty_end", 32'(s_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
